// File: rtl/dac_event_trigger.sv
// Qualifies threshold hits over N sample ticks and fires a registered TTL trigger; trig_out rises one dataclk after the qualifying tick.
// No backpressure: every sample tick is evaluated, and hits arriving during PULSE/REFRACT are dropped.
module dac_event_trigger #(
  parameter int CNT_W = 16
) (
  input  logic             dataclk,
  input  logic             reset,
  input  logic             sample_CLK_out,
  input  logic             thrsh_in,
  input  logic             window_in,
  input  logic             use_window,
  input  logic             trig_en,
  input  logic [3:0]       min_above,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] refractory,
  input  logic             count_clr,
  output logic             trig_out,
  output logic             busy,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PULSE   = 2'd2,
    REFRACT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sclk_d;
  logic             tick;
  logic             hit;
  logic             entry;
  logic [3:0]       min_eff;
  logic [3:0]       run_q, run_d, run_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] rf_q, rf_d;

  // Same-clock sample strobe, so a single flop is enough for edge detection
  assign tick    = sample_CLK_out & ~sclk_d;
  assign hit     = thrsh_in & (window_in | ~use_window);
  assign min_eff = (min_above == 4'd0) ? 4'd1 : min_above;
  assign run_inc = run_q + 4'd1;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    rf_d    = rf_q;
    entry   = 1'b0;

    if (!trig_en) begin
      state_d = IDLE;
      run_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick && hit) begin
            if (min_eff == 4'd1) begin
              entry = 1'b1;
            end else begin
              state_d = QUALIFY;
              run_d   = 4'd1;
            end
          end
        end
        QUALIFY: begin
          // min_above is live here; >= lets a lowered threshold fire on the next hit
          if (tick) begin
            if (!hit) begin
              state_d = IDLE;
              run_d   = '0;
            end else if (run_inc >= min_eff) begin
              entry = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end
        end
        PULSE: begin
          if (tick) begin
            if (cnt_inc == pw_q) begin
              state_d = (rf_q == '0) ? IDLE : REFRACT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        REFRACT: begin
          if (tick) begin
            if (cnt_inc == rf_q) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (entry) begin
        state_d = PULSE;
        run_d   = '0;
        cnt_d   = '0;
        pw_d    = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
        rf_d    = refractory;
      end
    end
  end

  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      sclk_d      <= 1'b0;
      state_q     <= IDLE;
      run_q       <= '0;
      cnt_q       <= '0;
      pw_q        <= '0;
      rf_q        <= '0;
      trig_out    <= 1'b0;
      busy        <= 1'b0;
      event_count <= '0;
    end else begin
      sclk_d   <= sample_CLK_out;
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      pw_q     <= pw_d;
      rf_q     <= rf_d;
      trig_out <= (state_d == PULSE);
      busy     <= (state_d == PULSE) || (state_d == REFRACT);
      // Clear wins over a coincident trigger
      if (count_clr) begin
        event_count <= '0;
      end else if (entry && (event_count != '1)) begin
        event_count <= event_count + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dac_event_trigger.sv
// Directed bench for dac_event_trigger: per-sample vector table plus hand-written multi-cycle sequences.
module tb_dac_event_trigger;

  localparam int CNT_W = 8;

  logic             dataclk = 1'b0;
  logic             reset;
  logic             sample_CLK_out;
  logic             thrsh_in;
  logic             window_in;
  logic             use_window;
  logic             trig_en;
  logic [3:0]       min_above;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] refractory;
  logic             count_clr;
  logic             trig_out;
  logic             busy;
  logic [CNT_W-1:0] event_count;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  min_above;
    logic        use_window;
    logic [7:0]  pw;
    logic [7:0]  rf;
    logic [15:0] th;
    logic [15:0] wn;
    logic [15:0] exp_trig;
    logic [15:0] exp_busy;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [8];

  dac_event_trigger #(.CNT_W(CNT_W)) dut (
    .dataclk        (dataclk),
    .reset          (reset),
    .sample_CLK_out (sample_CLK_out),
    .thrsh_in       (thrsh_in),
    .window_in      (window_in),
    .use_window     (use_window),
    .trig_en        (trig_en),
    .min_above      (min_above),
    .pulse_width    (pulse_width),
    .refractory     (refractory),
    .count_clr      (count_clr),
    .trig_out       (trig_out),
    .busy           (busy),
    .event_count    (event_count),
    .state          (state)
  );

  always #5 dataclk = ~dataclk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Returns to IDLE with a cleared count and loads a fresh configuration
  task automatic setup(input logic [3:0] ma, input logic uw, input logic [7:0] pw, input logic [7:0] rf);
    @(negedge dataclk);
    trig_en        = 1'b0;
    count_clr      = 1'b1;
    sample_CLK_out = 1'b0;
    thrsh_in       = 1'b0;
    window_in      = 1'b0;
    min_above      = ma;
    use_window     = uw;
    pulse_width    = pw;
    refractory     = rf;
    @(negedge dataclk);
    trig_en   = 1'b1;
    count_clr = 1'b0;
  endtask

  // One sample: 2 cycles high, 2 low; outputs captured just after the tick edge
  task automatic run_sample(input logic th, input logic wn, output logic tr, output logic bz);
    @(negedge dataclk);
    thrsh_in       = th;
    window_in      = wn;
    sample_CLK_out = 1'b1;
    @(negedge dataclk);
    tr = trig_out;
    bz = busy;
    @(negedge dataclk);
    sample_CLK_out = 1'b0;
    @(negedge dataclk);
  endtask

  initial begin
    logic [15:0] tr_v, bz_v;
    logic        t, b, any_t;
    int          ntrig, nref, first_hi;

    // min, use_window, pw, rf, thrsh, window, trig, busy, count
    vecs[0] = '{4'd1, 1'b0, 8'd3, 8'd5, 16'h0001, 16'h0000, 16'h0007, 16'h00FF, 8'd1};
    vecs[1] = '{4'd4, 1'b0, 8'd2, 8'd0, 16'h00F7, 16'h0000, 16'h0180, 16'h0180, 8'd1};
    vecs[2] = '{4'd1, 1'b1, 8'd1, 8'd1, 16'hFFFF, 16'h0010, 16'h0010, 16'h0030, 8'd1};
    vecs[3] = '{4'd1, 1'b0, 8'd1, 8'd0, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 8'd1};
    // Held hit: pulse 1 + refractory 2 + one idle tick before re-qualifying
    vecs[4] = '{4'd1, 1'b0, 8'd1, 8'd2, 16'hFFFF, 16'h0000, 16'h1111, 16'h7777, 8'd4};
    vecs[5] = '{4'd0, 1'b0, 8'd0, 8'd0, 16'h0002, 16'h0000, 16'h0002, 16'h0002, 8'd1};
    vecs[6] = '{4'd2, 1'b0, 8'd1, 8'd0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 8'd0};
    vecs[7] = '{4'd2, 1'b0, 8'd1, 8'd0, 16'h0006, 16'h0000, 16'h0004, 16'h0004, 8'd1};

    reset          = 1'b0;
    sample_CLK_out = 1'b0;
    thrsh_in       = 1'b0;
    window_in      = 1'b0;
    use_window     = 1'b0;
    trig_en        = 1'b0;
    min_above      = 4'd1;
    pulse_width    = 8'd1;
    refractory     = 8'd0;
    count_clr      = 1'b0;
    repeat (3) @(negedge dataclk);
    check("reset trig_out", 32'(trig_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset event_count", 32'(event_count), 32'd0);
    check("reset state", 32'(state), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      setup(vecs[v].min_above, vecs[v].use_window, vecs[v].pw, vecs[v].rf);
      tr_v = '0;
      bz_v = '0;
      for (int s = 0; s < 16; s++) begin
        run_sample(vecs[v].th[s], vecs[v].wn[s], t, b);
        tr_v[s] = t;
        bz_v[s] = b;
      end
      check($sformatf("vec%0d trig", v), 32'(tr_v), 32'(vecs[v].exp_trig));
      check($sformatf("vec%0d busy", v), 32'(bz_v), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d count", v), 32'(event_count), 32'(vecs[v].exp_cnt));
    end

    // Slow sample clock (period 20): 60-cycle pulse then 100 refractory cycles
    setup(4'd1, 1'b0, 8'd3, 8'd5);
    ntrig = 0;
    nref = 0;
    first_hi = -1;
    for (int cyc = 0; cyc < 220; cyc++) begin
      @(negedge dataclk);
      if (trig_out) begin
        ntrig++;
        if (first_hi < 0) first_hi = cyc;
      end
      if (busy && !trig_out) nref++;
      sample_CLK_out = ((cyc % 20) < 10);
      thrsh_in       = (cyc < 20);
    end
    check("slow first_high_cycle", 32'(first_hi), 32'd1);
    check("slow pulse_cycles", 32'(ntrig), 32'd60);
    check("slow refract_cycles", 32'(nref), 32'd100);
    check("slow event_count", 32'(event_count), 32'd1);

    // Lowering min_above mid-qualification fires on the next hit
    setup(4'd4, 1'b0, 8'd2, 8'd0);
    run_sample(1'b1, 1'b0, t, b);
    run_sample(1'b1, 1'b0, t, b);
    min_above = 4'd2;
    run_sample(1'b1, 1'b0, t, b);
    check("live min_above trig", 32'(t), 32'd1);

    // Abort mid-pulse
    setup(4'd1, 1'b0, 8'd5, 8'd3);
    run_sample(1'b1, 1'b0, t, b);
    run_sample(1'b0, 1'b0, t, b);
    trig_en = 1'b0;
    @(negedge dataclk);
    check("abort trig_out", 32'(trig_out), 32'd0);
    check("abort state", 32'(state), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort event_count kept", 32'(event_count), 32'd1);
    trig_en = 1'b1;

    // count_clr coincident with a pulse entry
    @(negedge dataclk);
    thrsh_in       = 1'b1;
    sample_CLK_out = 1'b1;
    count_clr      = 1'b1;
    @(negedge dataclk);
    count_clr = 1'b0;
    check("clr_on_entry event_count", 32'(event_count), 32'd0);
    check("clr_on_entry trig_out", 32'(trig_out), 32'd1);
    sample_CLK_out = 1'b0;
    thrsh_in       = 1'b0;
    repeat (2) @(negedge dataclk);

    // Saturation: one trigger every 4 cycles with a 2-cycle sample period
    setup(4'd1, 1'b0, 8'd1, 8'd0);
    thrsh_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge dataclk);
      sample_CLK_out = ~sample_CLK_out;
    end
    check("sat partial count", 32'(event_count), 32'd10);
    for (int i = 0; i < 1160; i++) begin
      @(negedge dataclk);
      sample_CLK_out = ~sample_CLK_out;
    end
    check("sat final count", 32'(event_count), 32'hFF);
    @(negedge dataclk);
    thrsh_in       = 1'b0;
    sample_CLK_out = 1'b0;

    // Async reset between edges during PULSE
    setup(4'd1, 1'b0, 8'd5, 8'd0);
    run_sample(1'b1, 1'b0, t, b);
    check("pre_reset trig_out", 32'(t), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async trig_out", 32'(trig_out), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async event_count", 32'(event_count), 32'd0);
    check("async state", 32'(state), 32'd0);
    @(negedge dataclk);
    reset = 1'b1;
    any_t = 1'b0;
    for (int s = 0; s < 3; s++) begin
      run_sample(1'b0, 1'b0, t, b);
      any_t = any_t | t | trig_out;
    end
    check("post_reset quiet", 32'(any_t), 32'd0);
    run_sample(1'b1, 1'b0, t, b);
    check("post_reset new trigger", 32'(t), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
